// File: rtl/key_debounce.sv
// key_debounce: synchronises, debounces and qualifies a push-button.
// Emits a debounced level plus press, release and long-press pulses.
module key_debounce #(
  parameter int DEB_CNT    = 20,
  parameter int LONG_CNT   = 100,
  parameter int BTN_ACTIVE = 1
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic i_btn,
  output logic o_btn,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam int DW = $clog2(DEB_CNT) + 1;
  localparam int LW = $clog2(LONG_CNT) + 1;

  localparam logic ACT = (BTN_ACTIVE != 0);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CNT - 1);
  localparam logic [LW-1:0] LONG_TOP  = LW'(LONG_CNT);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } state_t;

  state_t state;
  state_t state_nx;

  logic s1;
  logic s2;
  logic btn_s;

  logic [DW-1:0] deb_cnt;
  logic [DW-1:0] deb_nx;
  logic [LW-1:0] long_cnt;
  logic [LW-1:0] long_nx;

  logic btn_nx;
  logic press_nx;
  logic rel_nx;
  logic long_p_nx;

  assign btn_s = (s2 == ACT);

  // Two-flop synchroniser; idles at the released level.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1 <= ~ACT;
      s2 <= ~ACT;
    end else begin
      s1 <= i_btn;
      s2 <= s1;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      deb_cnt   <= '0;
      long_cnt  <= '0;
      o_btn     <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_long    <= 1'b0;
    end else begin
      state     <= state_nx;
      deb_cnt   <= deb_nx;
      long_cnt  <= long_nx;
      o_btn     <= btn_nx;
      o_press   <= press_nx;
      o_release <= rel_nx;
      o_long    <= long_p_nx;
    end
  end

  // Next-state logic; long_cnt advances on every cycle spent in HELD,
  // so a release glitch delays o_long only by its RELEASE_DB cycles.
  always_comb begin
    state_nx  = state;
    deb_nx    = deb_cnt;
    long_nx   = long_cnt;
    btn_nx    = o_btn;
    press_nx  = 1'b0;
    rel_nx    = 1'b0;
    long_p_nx = 1'b0;
    unique case (state)
      IDLE: begin
        if (btn_s) begin
          state_nx = PRESS_DB;
          deb_nx   = '0;
        end
      end
      PRESS_DB: begin
        if (!btn_s) begin
          state_nx = IDLE;
        end else if (deb_cnt == DEB_LAST) begin
          state_nx = HELD;
          btn_nx   = 1'b1;
          press_nx = 1'b1;
          long_nx  = '0;
        end else begin
          deb_nx = deb_cnt + 1'b1;
        end
      end
      HELD: begin
        if (long_cnt < LONG_TOP) begin
          long_nx   = long_cnt + 1'b1;
          long_p_nx = (long_cnt == LONG_LAST);
        end
        if (!btn_s) begin
          state_nx = RELEASE_DB;
          deb_nx   = '0;
        end
      end
      RELEASE_DB: begin
        if (btn_s) begin
          state_nx = HELD;
        end else if (deb_cnt == DEB_LAST) begin
          state_nx = IDLE;
          btn_nx   = 1'b0;
          rel_nx   = 1'b1;
        end else begin
          deb_nx = deb_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
